uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

Frame controller for the UART transmitter. It accepts a parallel byte through a valid/ack handshake, computes optional parity, and sequences the existing 8-bit serializer through start, data, parity and stop phases. It drives the TX line through an internal output mux. It sits between the host-side register interface and the `Serializer` instance and owns all frame timing.

## Interface
- `DATA_WIDTH`, default 8: payload width; must match the serializer.
- `Clk`, input, 1: clock, one TX bit per cycle.
- `Reset`, input, 1: asynchronous, active-low.
- `P_Data`, input, DATA_WIDTH: byte to send; sampled only on accept.
- `Data_Valid`, input, 1: host request.
- `PAR_EN`, input, 1: 1 = insert parity bit; sampled on accept.
- `PAR_TYP`, input, 1: 0 = even, 1 = odd; sampled on accept.
- `ser_data`, input, 1: serial bit from the serializer.
- `ser_done`, input, 1: serializer flag, high during its last data bit.
- `ser_en`, output, 1: one-cycle load/activate pulse to the serializer.
- `ser_err`, output, 1: one-cycle pulse when the bit counter expires without `ser_done`.
- `Data_Ack`, output, 1: one-cycle pulse; request accepted.
- `busy`, output, 1: frame in progress.
- `TX_OUT`, output, 1: serial line, idle high.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. The state register is asynchronously reset to IDLE.
- Reset values:
  - `TX_OUT`=1, `busy`=0, `ser_en`=0, `Data_Ack`=0, `ser_err`=0.
  - Internal registers are cleared: bit counter=0, `par_bit`=0, latched `PAR_EN` and `PAR_TYP`=0.
- Accept:
  - Accept occurs when `Data_Valid`=1 and state ∈ {IDLE, STOP}.
  - On accept, the controller latches `PAR_EN` and `PAR_TYP` and computes `par_bit` = ^P_Data XOR PAR_TYP.
  - The accept cycle pulses `Data_Ack` and moves the state to START.
- `Data_Valid` in START, DATA or PARITY is ignored, with no ack. The host must hold it until ack.
- START: `TX_OUT`=0 and `ser_en`=1 for exactly this cycle. Next state is DATA and the bit counter clears to 0.
- DATA:
  - `TX_OUT`=`ser_data`, and the bit counter increments each cycle.
  - When `ser_done`=1, the next state is PARITY if the latched PAR_EN is set, else STOP.
  - If the counter reaches DATA_WIDTH-1 with `ser_done`=0, the controller pulses `ser_err` and leaves DATA anyway, taking the same branch.
- PARITY: `TX_OUT`=`par_bit` for one cycle, then STOP.
- STOP: `TX_OUT`=1 for one cycle. Next state is START on accept (back-to-back, no idle gap), else IDLE.
- `busy`=1 in START, DATA and PARITY. It is 0 in IDLE and STOP, so STOP doubles as the accept window.
- `TX_OUT` is a combinational decode of registered state plus `par_bit` and `ser_data`. `ser_data` comes from a register, so the line is glitch-free per bit.

## Timing
- Accept edge to first start bit: 1 cycle.
- Frame length: 1 + DATA_WIDTH + PAR_EN + 1 cycles, i.e. 10 cycles without parity, 11 with.
- Back-to-back frames: a new start bit directly follows the stop cycle, giving a continuous stream.
- `ser_en` is high in START, so the serializer loads on that edge and presents bit 0 in the first DATA cycle.
- Parity is computed from the input byte, not from the serializer output. `P_Data` may change after the ack.
- Asynchronous reset mid-frame:
  - The FSM returns to IDLE immediately and `TX_OUT` goes to 1.
  - The partial frame is aborted and no ack is re-issued.
  - No recovery sequence is needed; the serializer receives the same reset.
- `Data_Valid` held high continuously: the controller accepts once per frame, in the STOP cycle.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3 bits);
  - the parity type constants `PAR_EVEN`=0 and `PAR_ODD`=1.
- One sub-module, `parity_calc`: combinational reduction XOR with a type select, used at accept.
- The serializer and any top-level glue stay outside this block.

## Test plan
- `P_Data`=0xA5, PAR_EN=0: `TX_OUT` = 0,1,0,1,0,0,1,0,1,1 (start, LSB-first, stop). One `Data_Ack` and one `ser_en` pulse; `busy` high for 9 cycles.
- 0xA5 with PAR_EN=1:
  - PAR_TYP=0 gives parity bit 0; PAR_TYP=1 gives parity bit 1.
  - Frame length is 11 cycles.
- `Data_Valid` held high with 0x00 then 0xFF: the second start bit immediately follows the first stop. `Data_Ack` is seen in the first IDLE cycle and in the STOP cycle only.
- `Data_Valid` pulsed during DATA: no ack and the frame is unaffected. `busy` stays 1.
- Serializer model with `ser_done` stuck low: `ser_err` pulses once after 8 DATA cycles, the frame completes with a stop bit, and the FSM reaches IDLE.
- Reset asserted in the 4th DATA cycle: `TX_OUT`=1 and `busy`=0 immediately. A subsequent 0x3C frame is transmitted correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding and parity type codes.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_parity_calc.sv
// Parity of a payload word, even or odd as selected; purely combinational.
module parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  par_o
);

  // Reduction XOR, inverted for odd parity.
  always_comb begin
    par_o = 1'b0;
    case (par_typ_i)
      PAR_EVEN: par_o = ^data_i;
      PAR_ODD:  par_o = ~(^data_i);
      default:  par_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: accepts a byte, sequences the serializer
// through start/data/parity/stop and drives the TX line.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  ser_en,
  output logic                  ser_err,
  output logic                  Data_Ack,
  output logic                  busy,
  output logic                  TX_OUT
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_bit_q, par_bit_d;
  logic             par_en_q, par_en_d;
  logic             accept_s;
  logic             par_calc_s;

  parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity_calc (
    .data_i    (P_Data),
    .par_typ_i (PAR_TYP),
    .par_o     (par_calc_s)
  );

  // Next-state, counter and output decode; STOP doubles as the accept window.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
    ser_en    = 1'b0;
    ser_err   = 1'b0;
    Data_Ack  = 1'b0;
    busy      = 1'b0;
    TX_OUT    = 1'b1;
    accept_s  = Data_Valid && ((state_q == ST_IDLE) || (state_q == ST_STOP));

    if (accept_s) begin
      Data_Ack  = 1'b1;
      par_en_d  = PAR_EN;
      par_bit_d = par_calc_s;
    end else begin
      Data_Ack  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        busy    = 1'b1;
        TX_OUT  = 1'b0;
        ser_en  = 1'b1;
        cnt_d   = '0;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        busy   = 1'b1;
        TX_OUT = ser_data;
        cnt_d  = cnt_q + CNT_W'(1);
        // A missing ser_done at the last bit is flagged but the frame still closes.
        if (ser_done || (cnt_q == CNT_LAST)) begin
          ser_err = ~ser_done;
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        busy    = 1'b1;
        TX_OUT  = par_bit_q;
        state_d = ST_STOP;
      end
      ST_STOP: begin
        TX_OUT = 1'b1;
        if (accept_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and frame-context registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomized bench for uart_tx_ctrl with a serializer model and a bit-list
// reference of each expected frame.
module tb_uart_tx_ctrl;

  logic       Clk        = 1'b0;
  logic       Reset      = 1'b0;
  logic [7:0] P_Data     = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN     = 1'b0;
  logic       PAR_TYP    = 1'b0;
  logic       ser_data;
  logic       ser_done;
  logic       ser_en;
  logic       ser_err;
  logic       Data_Ack;
  logic       busy;
  logic       TX_OUT;

  int n_checks = 0;
  int n_errors = 0;
  bit exp_bits[$];
  bit stuck = 1'b0;

  logic [7:0] ser_byte;
  logic [7:0] sbuf;
  int         idx;
  logic       active;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .P_Data     (P_Data),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .ser_data   (ser_data),
    .ser_done   (ser_done),
    .ser_en     (ser_en),
    .ser_err    (ser_err),
    .Data_Ack   (Data_Ack),
    .busy       (busy),
    .TX_OUT     (TX_OUT)
  );

  always #5 Clk = ~Clk;

  // Serializer model: byte captured at ack, loaded on ser_en, bit 0 first.
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ser_byte <= 8'h00;
      sbuf     <= 8'h00;
      idx      <= 0;
      active   <= 1'b0;
      ser_data <= 1'b0;
      ser_done <= 1'b0;
    end else begin
      if (Data_Ack) ser_byte <= P_Data;
      if (ser_en) begin
        sbuf     <= ser_byte;
        ser_data <= ser_byte[0];
        ser_done <= 1'b0;
        idx      <= 1;
        active   <= 1'b1;
      end else if (active) begin
        if (idx >= 8) begin
          active   <= 1'b0;
          ser_data <= 1'b0;
          ser_done <= 1'b0;
        end else begin
          ser_data <= sbuf[idx];
          ser_done <= (idx == 7) && !stuck;
          idx      <= idx + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line-level picture of one frame: start, LSB-first data, optional parity, stop.
  function automatic void push_frame(input logic [7:0] d, input bit pe, input bit pt);
    exp_bits.push_back(1'b0);
    for (int b = 0; b < 8; b++) exp_bits.push_back(d[b]);
    if (pe) exp_bits.push_back((($countones(d) % 2) == 1) ^ pt);
    exp_bits.push_back(1'b1);
  endfunction

  task automatic run_frame(input logic [7:0] d, input bit pe, input bit pt,
                           input bit stk, input bit poke);
    int len;
    exp_bits.delete();
    push_frame(d, pe, pt);
    len = exp_bits.size();
    @(negedge Clk);
    P_Data = d; PAR_EN = pe; PAR_TYP = pt; stuck = stk; Data_Valid = 1'b1;
    #1;
    chk("ack", Data_Ack, 1);
    chk("acc_busy", busy, 0);
    @(posedge Clk);
    #1;
    Data_Valid = 1'b0;
    P_Data = 8'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
    for (int i = 0; i < len; i++) begin
      @(negedge Clk);
      chk("tx", TX_OUT, exp_bits[i]);
      chk("busy", busy, (i < len - 1));
      chk("ser_en", ser_en, (i == 0));
      chk("ser_err", ser_err, (stk && i == 8));
      chk("ack_mid", Data_Ack, 0);
      if (poke && i == 3) begin
        Data_Valid = 1'b1;
        #1;
        chk("nak", Data_Ack, 0);
      end
      if (poke && i == 5) Data_Valid = 1'b0;
    end
    @(negedge Clk);
    chk("idle_tx", TX_OUT, 1);
    chk("idle_busy", busy, 0);
  endtask

  task automatic run_b2b();
    exp_bits.delete();
    push_frame(8'h00, 1'b0, 1'b0);
    push_frame(8'hFF, 1'b0, 1'b0);
    @(negedge Clk);
    P_Data = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0; stuck = 1'b0; Data_Valid = 1'b1;
    #1;
    chk("b2b_ack0", Data_Ack, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      chk("b2b_tx", TX_OUT, exp_bits[i]);
      chk("b2b_ack", Data_Ack, (i == 9));
      chk("b2b_busy", busy, ((i % 10) != 9));
      if (i == 1) P_Data = 8'hFF;
      if (i == 10) Data_Valid = 1'b0;
    end
    @(negedge Clk);
    chk("b2b_idle", TX_OUT, 1);
  endtask

  task automatic run_reset_abort();
    @(negedge Clk);
    P_Data = 8'h5A; PAR_EN = 1'b1; PAR_TYP = 1'b0; stuck = 1'b0; Data_Valid = 1'b1;
    @(posedge Clk);
    #1;
    Data_Valid = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge Clk);
    chk("pre_rst_busy", busy, 1);
    Reset = 1'b0;
    #1;
    chk("rst_tx", TX_OUT, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ack", Data_Ack, 0);
    @(negedge Clk);
    chk("rst_hold_tx", TX_OUT, 1);
    Reset = 1'b1;
    run_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #3;
    chk("reset_tx", TX_OUT, 1);
    chk("reset_busy", busy, 0);
    chk("reset_ser_en", ser_en, 0);
    chk("reset_ack", Data_Ack, 0);
    chk("reset_err", ser_err, 0);
    @(negedge Clk);
    Reset = 1'b1;

    run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    run_b2b();
    run_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame(8'h71, 1'b1, 1'b1, 1'b1, 1'b0);
    run_reset_abort();

    for (int n = 0; n < 30; n++) begin
      run_frame(8'($urandom), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 3) == 0), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
